// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types for the two-port SDRAM request arbiter
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_DRAIN    = 2'd3
  } arb_state_t;

  typedef logic port_idx_t;

  localparam port_idx_t PORT0 = 1'b0;
  localparam port_idx_t PORT1 = 1'b1;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned LEN_W  = 8;

endpackage

// File: rtl/sdram_arb_rr.sv
// rtl/sdram_arb_rr.sv - 2-way round-robin grant; last_grant moves only on completion
module sdram_arb_rr
  import sdram_arb_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] i_req,
  input  logic       i_done,
  input  port_idx_t  i_done_port,
  output port_idx_t  o_grant
);

  port_idx_t r_last_grant;

  // Reset value PORT1 makes port 0 the winner of the first contested round.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= PORT1;
    end else if (i_done) begin
      r_last_grant <= i_done_port;
    end
  end

  always_comb begin
    o_grant = PORT0;
    if (i_req == 2'b11) begin
      o_grant = ~r_last_grant;
    end else if (i_req[1]) begin
      o_grant = PORT1;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - arbitrates two requesters onto one SDRAM core inport
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              reset_n,

  input  logic [STRB_W-1:0] m0_wr_i,
  input  logic              m0_rd_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_accept_o,
  output logic              m0_ack_o,
  output logic              m0_error_o,
  output logic [DATA_W-1:0] m0_rdata_o,

  input  logic [STRB_W-1:0] m1_wr_i,
  input  logic              m1_rd_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_accept_o,
  output logic              m1_ack_o,
  output logic              m1_error_o,
  output logic [DATA_W-1:0] m1_rdata_o,

  output logic [STRB_W-1:0] sd_wr_o,
  output logic              sd_rd_o,
  output logic [LEN_W-1:0]  sd_len_o,
  output logic [ADDR_W-1:0] sd_addr_o,
  output logic [DATA_W-1:0] sd_wdata_o,
  input  logic              sd_accept_i,
  input  logic              sd_ack_i,
  input  logic              sd_error_i,
  input  logic [DATA_W-1:0] sd_rdata_i
);

  localparam int unsigned    CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t       r_state;
  arb_state_t       w_next;
  port_idx_t        r_grant;
  port_idx_t        w_rr_grant;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0]        w_req;
  logic              w_latch;
  logic              w_accept;
  logic              w_ack;
  logic              w_error;
  logic [DATA_W-1:0] w_rdata;
  logic              w_done;
  logic              w_cnt_clr;
  logic              w_cnt_inc;
  logic              w_sel0;
  logic              w_sel1;

  assign w_req = {m1_rd_i | (|m1_wr_i), m0_rd_i | (|m0_wr_i)};

  sdram_arb_rr u_rr (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_req       (w_req),
    .i_done      (w_done),
    .i_done_port (r_grant),
    .o_grant     (w_rr_grant)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_grant <= PORT0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_grant <= w_rr_grant;
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_latch   = 1'b0;
    w_accept  = 1'b0;
    w_ack     = 1'b0;
    w_error   = 1'b0;
    w_rdata   = '0;
    w_done    = 1'b0;
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_latch = 1'b1;
          w_next  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (sd_accept_i) begin
          w_accept  = 1'b1;
          w_cnt_clr = 1'b1;
          if (sd_ack_i) begin
            w_ack   = 1'b1;
            w_error = sd_error_i;
            w_rdata = sd_rdata_i;
            w_done  = 1'b1;
            w_next  = ST_IDLE;
          end else begin
            w_next = ST_WAIT_ACK;
          end
        end
      end
      ST_WAIT_ACK: begin
        if (sd_ack_i) begin
          w_ack   = 1'b1;
          w_error = sd_error_i;
          w_rdata = sd_rdata_i;
          w_done  = 1'b1;
          w_next  = ST_IDLE;
        end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
          // Forced error completion; the late core ack is swallowed in DRAIN.
          w_ack   = 1'b1;
          w_error = 1'b1;
          w_done  = 1'b1;
          w_next  = ST_DRAIN;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (sd_ack_i) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    sd_rd_o    = 1'b0;
    sd_wr_o    = '0;
    sd_addr_o  = '0;
    sd_wdata_o = '0;
    if (r_state == ST_ISSUE) begin
      if (r_grant == PORT1) begin
        sd_rd_o    = m1_rd_i;
        sd_wr_o    = m1_wr_i;
        sd_addr_o  = m1_addr_i;
        sd_wdata_o = m1_wdata_i;
      end else begin
        sd_rd_o    = m0_rd_i;
        sd_wr_o    = m0_wr_i;
        sd_addr_o  = m0_addr_i;
        sd_wdata_o = m0_wdata_i;
      end
    end
  end

  assign sd_len_o = '0;

  assign w_sel0 = (r_grant == PORT0);
  assign w_sel1 = (r_grant == PORT1);

  assign m0_accept_o = w_accept & w_sel0;
  assign m0_ack_o    = w_ack & w_sel0;
  assign m0_error_o  = w_error & w_sel0;
  assign m0_rdata_o  = w_sel0 ? w_rdata : '0;

  assign m1_accept_o = w_accept & w_sel1;
  assign m1_ack_o    = w_ack & w_sel1;
  assign m1_error_o  = w_error & w_sel1;
  assign m1_rdata_o  = w_sel1 ? w_rdata : '0;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed and random checks against a transaction-level model
module tb_sdram_port_arbiter;

  localparam int TMO = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic [3:0]  wr    [2];
  logic        rd    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        sd_accept, sd_ack, sd_error;
  logic [31:0] sd_rdata;

  logic        m0_accept_o, m0_ack_o, m0_error_o;
  logic [31:0] m0_rdata_o;
  logic        m1_accept_o, m1_ack_o, m1_error_o;
  logic [31:0] m1_rdata_o;
  logic [3:0]  o_sd_wr;
  logic        o_sd_rd;
  logic [7:0]  o_sd_len;
  logic [31:0] o_sd_addr, o_sd_wdata;

  sdram_port_arbiter #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .m0_wr_i     (wr[0]),
    .m0_rd_i     (rd[0]),
    .m0_addr_i   (addr[0]),
    .m0_wdata_i  (wdata[0]),
    .m0_accept_o (m0_accept_o),
    .m0_ack_o    (m0_ack_o),
    .m0_error_o  (m0_error_o),
    .m0_rdata_o  (m0_rdata_o),
    .m1_wr_i     (wr[1]),
    .m1_rd_i     (rd[1]),
    .m1_addr_i   (addr[1]),
    .m1_wdata_i  (wdata[1]),
    .m1_accept_o (m1_accept_o),
    .m1_ack_o    (m1_ack_o),
    .m1_error_o  (m1_error_o),
    .m1_rdata_o  (m1_rdata_o),
    .sd_wr_o     (o_sd_wr),
    .sd_rd_o     (o_sd_rd),
    .sd_len_o    (o_sd_len),
    .sd_addr_o   (o_sd_addr),
    .sd_wdata_o  (o_sd_wdata),
    .sd_accept_i (sd_accept),
    .sd_ack_i    (sd_ack),
    .sd_error_i  (sd_error),
    .sd_rdata_i  (sd_rdata)
  );

  int n_vec = 0;
  int n_err = 0;

  // Transaction-level view: one owner at a time, plus a debt of one core ack after a timeout.
  bit mdl_busy, mdl_acc, mdl_drain;
  int mdl_port, mdl_last, mdl_wait;

  int          obs_acc [2], obs_ack [2], obs_err [2], obs_ack_cyc [2];
  logic [31:0] obs_rdata [2];
  int          obs_sd_first, cyc, code;
  bit          m1_seen;
  int          acc_order [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq(tag, 64'(|{m0_accept_o, m0_ack_o, m0_error_o, m0_rdata_o,
                        m1_accept_o, m1_ack_o, m1_error_o, m1_rdata_o,
                        o_sd_rd, o_sd_wr, o_sd_len, o_sd_addr, o_sd_wdata}), 64'd0);
  endtask

  task automatic clr_obs();
    for (int p = 0; p < 2; p++) begin
      obs_acc[p] = 0; obs_ack[p] = 0; obs_err[p] = 0; obs_ack_cyc[p] = -1; obs_rdata[p] = '0;
    end
    obs_sd_first = -1;
    cyc          = 0;
    m1_seen      = 1'b0;
    acc_order.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check_quiet("reset_outputs_zero");
    mdl_busy = 1'b0; mdl_acc = 1'b0; mdl_drain = 1'b0;
    mdl_port = 0; mdl_last = 1; mdl_wait = 0;
    for (int p = 0; p < 2; p++) begin
      rd[p] = 1'b0; wr[p] = 4'd0;
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick();
    logic [1:0]  pend, e_acc, e_ack, e_err;
    logic [31:0] e_rd0, e_rd1, e_addr, e_wdata;
    logic        e_sdrd;
    logic [3:0]  e_sdwr;
    bit          fin;
    #1;
    pend  = {rd[1] | (|wr[1]), rd[0] | (|wr[0])};
    e_acc = '0; e_ack = '0; e_err = '0; e_rd0 = '0; e_rd1 = '0;
    e_sdrd = 1'b0; e_sdwr = 4'd0; e_addr = '0; e_wdata = '0; fin = 1'b0;
    if (mdl_busy && !mdl_acc) begin
      e_sdrd = rd[mdl_port]; e_sdwr = wr[mdl_port];
      e_addr = addr[mdl_port]; e_wdata = wdata[mdl_port];
      if (sd_accept) begin
        e_acc[mdl_port] = 1'b1;
        mdl_acc  = 1'b1;
        mdl_wait = 0;
        if (sd_ack) begin
          e_ack[mdl_port] = 1'b1; e_err[mdl_port] = sd_error;
          if (mdl_port == 0) e_rd0 = sd_rdata; else e_rd1 = sd_rdata;
          fin = 1'b1;
        end
      end
    end else if (mdl_busy) begin
      if (sd_ack) begin
        e_ack[mdl_port] = 1'b1; e_err[mdl_port] = sd_error;
        if (mdl_port == 0) e_rd0 = sd_rdata; else e_rd1 = sd_rdata;
        fin = 1'b1;
      end else if (mdl_wait + 1 == TMO) begin
        e_ack[mdl_port] = 1'b1; e_err[mdl_port] = 1'b1;
        fin = 1'b1; mdl_drain = 1'b1;
      end else begin
        mdl_wait++;
      end
    end else if (mdl_drain) begin
      if (sd_ack) mdl_drain = 1'b0;
    end else if (pend != 2'b00) begin
      mdl_port = (pend == 2'b11) ? 1 - mdl_last : (pend[1] ? 1 : 0);
      mdl_busy = 1'b1;
      mdl_acc  = 1'b0;
    end
    if (fin) begin
      mdl_busy = 1'b0;
      mdl_last = mdl_port;
    end

    check_eq("m0_accept", 64'(m0_accept_o), 64'(e_acc[0]));
    check_eq("m1_accept", 64'(m1_accept_o), 64'(e_acc[1]));
    check_eq("m0_ack",    64'(m0_ack_o),    64'(e_ack[0]));
    check_eq("m1_ack",    64'(m1_ack_o),    64'(e_ack[1]));
    check_eq("m0_error",  64'(m0_error_o),  64'(e_err[0]));
    check_eq("m1_error",  64'(m1_error_o),  64'(e_err[1]));
    check_eq("m0_rdata",  64'(m0_rdata_o),  64'(e_rd0));
    check_eq("m1_rdata",  64'(m1_rdata_o),  64'(e_rd1));
    check_eq("sd_rd",     64'(o_sd_rd),     64'(e_sdrd));
    check_eq("sd_wr",     64'(o_sd_wr),     64'(e_sdwr));
    check_eq("sd_addr",   64'(o_sd_addr),   64'(e_addr));
    check_eq("sd_wdata",  64'(o_sd_wdata),  64'(e_wdata));
    check_eq("sd_len",    64'(o_sd_len),    64'd0);

    if (m0_accept_o) begin obs_acc[0]++; acc_order.push_back(0); end
    if (m1_accept_o) begin obs_acc[1]++; acc_order.push_back(1); end
    if (m0_ack_o) begin
      obs_ack[0]++; obs_ack_cyc[0] = cyc; obs_rdata[0] = m0_rdata_o;
      if (m0_error_o) obs_err[0]++;
    end
    if (m1_ack_o) begin
      obs_ack[1]++; obs_ack_cyc[1] = cyc; obs_rdata[1] = m1_rdata_o;
      if (m1_error_o) obs_err[1]++;
    end
    if ((o_sd_rd || o_sd_wr != 4'd0) && obs_sd_first < 0) obs_sd_first = cyc;
    if (m1_accept_o || m1_ack_o || m1_error_o || m1_rdata_o != 32'd0) m1_seen = 1'b1;

    for (int p = 0; p < 2; p++) begin
      if (e_acc[p]) begin
        rd[p] = 1'b0; wr[p] = 4'd0;
      end
    end
    cyc++;
    @(negedge clock);
  endtask

  function automatic int order_code(input int n);
    int c = 0;
    for (int i = 0; i < acc_order.size() && i < n; i++) c = c * 10 + acc_order[i] + 1;
    return c;
  endfunction

  initial begin
    reset_n = 1'b1;
    for (int p = 0; p < 2; p++) begin
      rd[p] = 1'b0; wr[p] = 4'd0; addr[p] = '0; wdata[p] = '0;
    end
    sd_accept = 1'b0; sd_ack = 1'b0; sd_error = 1'b0; sd_rdata = '0;
    #2;
    do_reset();

    // Single read: accept on third ISSUE cycle, ack on fifth WAIT_ACK cycle.
    clr_obs();
    rd[0] = 1'b1; addr[0] = 32'h100;
    for (int c = 0; c < 12; c++) begin
      sd_accept = (c == 3);
      sd_ack    = (c == 8);
      sd_rdata  = (c == 8) ? 32'hDEADBEEF : 32'h0;
      tick();
    end
    check_eq("t36_acc_cnt",   64'(obs_acc[0]), 64'd1);
    check_eq("t36_ack_cnt",   64'(obs_ack[0]), 64'd1);
    check_eq("t36_rdata",     64'(obs_rdata[0]), 64'hDEADBEEF);
    check_eq("t36_ack_cyc",   64'(obs_ack_cyc[0]), 64'd8);
    check_eq("t36_sd_lat",    64'(obs_sd_first), 64'd1);
    check_eq("t36_m1_quiet",  64'(m1_seen), 64'd0);

    // Core never acks: forced error at 8th wait cycle, late ack swallowed, port1 then served.
    clr_obs();
    rd[0] = 1'b1; addr[0] = 32'h300;
    sd_error = 1'b0; sd_rdata = 32'hA5A5A5A5;
    for (int c = 0; c < 18; c++) begin
      if (c == 10) begin wr[1] = 4'hF; addr[1] = 32'h200; wdata[1] = 32'h55; end
      sd_accept = 1'b1;
      sd_ack    = (c == 12 || c == 16);
      tick();
    end
    check_eq("t39_to_cyc",    64'(obs_ack_cyc[0]), 64'd9);
    check_eq("t39_to_err",    64'(obs_err[0]), 64'd1);
    check_eq("t39_to_rdata",  64'(obs_rdata[0]), 64'd0);
    check_eq("t39_m0_acks",   64'(obs_ack[0]), 64'd1);
    check_eq("t39_p1_ack",    64'(obs_ack[1]), 64'd1);
    check_eq("t39_p1_cyc",    64'(obs_ack_cyc[1]), 64'd16);

    // Simultaneous write pairs straight after reset; core accepts and acks same cycle.
    do_reset();
    clr_obs();
    sd_accept = 1'b1; sd_ack = 1'b1; sd_rdata = 32'h0;
    for (int c = 0; c < 8; c++) begin
      if (c == 0 || c == 4) begin
        wr[0] = 4'hF; addr[0] = 32'h10 + c; wdata[0] = 32'h1;
        wr[1] = 4'h3; addr[1] = 32'h20 + c; wdata[1] = 32'h2;
      end
      tick();
    end
    check_eq("t37_order", 64'(order_code(8)), 64'd1212);
    check_eq("t40_ack_cnt", 64'(obs_ack[0] + obs_ack[1]), 64'd4);

    // Port0 always busy, port1 asks once: it must be served second.
    clr_obs();
    for (int c = 0; c < 10; c++) begin
      if (!rd[0] && wr[0] == 4'd0) begin rd[0] = 1'b1; addr[0] = $urandom; end
      if (c == 0) begin wr[1] = 4'hC; addr[1] = 32'h444; wdata[1] = 32'h9; end
      tick();
    end
    repeat (4) tick();
    check_eq("t38_order",  64'(order_code(3)), 64'd121);
    check_eq("t38_p1_ack", 64'(obs_ack[1]), 64'd1);

    // Reset while an ack is being forwarded: outputs drop at once, stray ack ignored after.
    clr_obs();
    rd[0] = 1'b1; addr[0] = 32'h40;
    sd_accept = 1'b1; sd_ack = 1'b0;
    tick();
    tick();
    sd_accept = 1'b0;
    tick();
    sd_ack = 1'b1; sd_error = 1'b0; sd_rdata = 32'h12345678;
    #1;
    check_eq("t41_ack_live", 64'(m0_ack_o), 64'd1);
    #1;
    do_reset();
    tick();
    sd_ack = 1'b0;
    tick();
    check_eq("t41_no_ack", 64'(obs_ack[0] + obs_ack[1]), 64'd0);

    // Random traffic: first half ack-rich, second half ack-starved to provoke timeouts.
    for (int i = 0; i < 4000; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!rd[p] && wr[p] == 4'd0 && $urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 1) == 0) rd[p] = 1'b1;
          else wr[p] = 4'($urandom_range(1, 15));
          addr[p]  = $urandom;
          wdata[p] = $urandom;
        end
      end
      sd_accept = ($urandom_range(0, 1) == 0);
      sd_ack    = (i < 2000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 11) == 0);
      sd_error  = ($urandom_range(0, 1) == 0);
      sd_rdata  = $urandom;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, width of request address.
REQ-002 Parameter TIMEOUT, 1024, max cycles in WAIT_ACK before forced error completion; 0 disables the timeout.
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 mN_wr_i  input  4  (N=0,1) write byte strobes; nonzero = write request.
REQ-006 mN_rd_i  input  1  read request.
REQ-007 mN_addr_i  input  ADDR_W  request address.
REQ-008 mN_wdata_i  input  32  write data.
REQ-009 mN_accept_o  output  1  request taken by SDRAM core.
REQ-010 mN_ack_o  output  1  one-cycle completion pulse.
REQ-011 mN_error_o  output  1  completion error, valid with ack.
REQ-012 mN_rdata_o  output  32  read data, valid with ack.
REQ-013 sd_wr_o, sd_rd_o, sd_addr_o, sd_wdata_o  output  4/1/ADDR_W/32  request to SDRAM core inport; sd_len_o output 8, tied 0.
REQ-014 sd_accept_i, sd_ack_i, sd_error_i, sd_rdata_i  input  1/1/1/32  SDRAM core responses.

Function
REQ-015 Requester holds rd/wr/addr/wdata stable from assertion until its accept; mN_rd_i and nonzero mN_wr_i never both asserted.
REQ-016 States: IDLE, ISSUE, WAIT_ACK, DRAIN; exactly one transaction outstanding at any time.
REQ-017 IDLE: if any requester pending, latch grant and go ISSUE next cycle; otherwise stay.
REQ-018 Arbitration round-robin: single requester wins; both pending -> port != last_grant wins; last_grant updates at completion.
REQ-019 ISSUE: sd_* driven from granted port's inputs (combinational mux); non-granted port sees accept=0.
REQ-020 sd_rd_o/sd_wr_o nonzero only in ISSUE; zero in all other states.
REQ-021 ISSUE with sd_accept_i=1: mN_accept_o=1 same cycle for granted port; next state WAIT_ACK, timeout counter cleared.
REQ-022 ISSUE with sd_accept_i and sd_ack_i both 1: forward accept and ack same cycle; next state IDLE.
REQ-023 WAIT_ACK with sd_ack_i=1: mN_ack_o=1, mN_error_o=sd_error_i, mN_rdata_o=sd_rdata_i same cycle to granted port; next IDLE.
REQ-024 mN_rdata_o and mN_error_o are 0 whenever mN_ack_o=0.
REQ-025 Request-to-sd_rd/wr latency: 1 cycle (IDLE cycle), no idle bubble when accept arrives first ISSUE cycle.
REQ-026 WAIT_ACK counter increments per cycle; when it reaches TIMEOUT (TIMEOUT!=0) without ack: mN_ack_o=1, mN_error_o=1, rdata=0, next DRAIN.
REQ-027 DRAIN: no grant issued; first sd_ack_i is discarded (not forwarded) and state returns IDLE.
REQ-028 sd_ack_i in IDLE is discarded.
REQ-029 Requests arriving during ISSUE/WAIT_ACK/DRAIN from the non-granted port wait; no starvation beyond one transaction.

Reset
REQ-030 reset_n low: state=IDLE, last_grant=1 (port 0 first), counter=0, all outputs 0, immediately and asynchronously.
REQ-031 Reset mid-transaction abandons it; no ack issued; first post-reset sd_ack_i discarded per REQ-028.
REQ-032 Deassertion takes effect on the next rising clock edge.

Structure
REQ-033 Package sdram_arb_pkg holds the state enum (2 bits) and port-index type.
REQ-034 Sub-module sdram_arb_rr: 2-way round-robin grant with last_grant register; remainder is the FSM and muxes.
REQ-035 No storage of request payload; muxed pass-through only.

Verification
REQ-036 Single read port0 addr 0x100, accept after 2 cycles, ack after 5 with rdata 0xDEADBEEF -> m0_accept once, m0_ack once with 0xDEADBEEF, m1 outputs 0.
REQ-037 Both ports request write same cycle after reset -> port0 granted first, port1 second; third simultaneous pair -> port0 again.
REQ-038 Port0 continuous requests, port1 one request -> grants alternate 0,1,0; port1 completes within two transactions.
REQ-039 TIMEOUT=8, core never acks -> m0_ack with error=1 at 8th WAIT_ACK cycle; later sd_ack discarded; next request grants normally.
REQ-040 Accept and ack same cycle -> m0_accept and m0_ack same cycle, state IDLE next.
REQ-041 reset_n low during WAIT_ACK -> outputs 0 at once, stray sd_ack after release ignored, no spurious mN_ack.
